mux_scan_sequencer: RTL
=======================

MUX_SCAN_SEQUENCER -- requirements
Module: mux_scan_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1: idle cycles between a sel change and the sample of mux_y; legal range 0..15.
REQ-002 Parameter CONTINUOUS, default 0: when 1, a new scan starts immediately after each word handshake.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request one 8-channel scan; sampled only in IDLE.
REQ-006 abort  input  1  synchronous scan cancel.
REQ-007 sel  output  3  select lines driven to the downstream 8:1 mux.
REQ-008 mux_y  input  1  selected mux output, fed back for sampling.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 word  output  8  assembled scan result; word[i] = mux_y sampled while sel==i.
REQ-011 word_valid  output  1  word is held and stable.
REQ-012 word_ready  input  1  consumer accepts word.

Function
REQ-013 FSM states: IDLE, SETTLE, SAMPLE, DONE; all outputs registered.
REQ-014 IDLE: sel=0, busy=0, word_valid=0; start=1 -> channel index 0, settle count cleared, next state SETTLE (SAMPLE if SETTLE_CYCLES=0).
REQ-015 SETTLE: sel=index; stay SETTLE_CYCLES cycles, then SAMPLE.
REQ-016 SAMPLE: capture mux_y into shadow bit [index]; index<7 -> index+1, next SETTLE (or SAMPLE if SETTLE_CYCLES=0); index==7 -> load word from shadow, next DONE.
REQ-017 Each channel costs SETTLE_CYCLES+1 cycles; word_valid rises 8*(SETTLE_CYCLES+1) clock edges after the edge that accepted start (16 at default).
REQ-018 DONE: word_valid=1, word and sel held stable until word_valid&&word_ready.
REQ-019 Handshake in DONE: CONTINUOUS=0 -> IDLE; CONTINUOUS=1 -> index 0, SETTLE (or SAMPLE), word_valid low for the duration of the new scan.
REQ-020 start while busy is ignored; no queuing.
REQ-021 word_ready while word_valid=0 has no effect.
REQ-022 abort=1 in any state -> IDLE next edge, shadow discarded, word keeps its last completed value, word_valid=0; abort wins over start, word_ready and SAMPLE completion in the same cycle.
REQ-023 word retains its last value after handshake until the next completed scan overwrites it.
REQ-024 Index wraps only via reload to 0; it never counts past 7.

Reset
REQ-025 rst=1 asynchronously forces state IDLE, sel=0, index=0, settle count=0, shadow=0, word=8'h00, word_valid=0, busy=0.
REQ-026 rst asserted mid-scan or in DONE discards all scan state; no word_valid pulse follows release.
REQ-027 After rst deasserts, the first start is honoured on the first rising edge at which it is sampled high.

Structure
REQ-028 Shared package mux_scan_pkg holds the state enum, NUM_CH=8, SEL_W=3 and SETTLE_W=4.
REQ-029 Settle counter and channel index are inline; no sub-module is required.

Verification
REQ-030 Mux model D=8'hA5, SETTLE_CYCLES=1, start pulse -> sel steps 0..7 with two cycles per value, word=8'hA5, word_valid high at edge 16, held until word_ready.
REQ-031 SETTLE_CYCLES=0, D=8'h3C -> sel changes every cycle, word=8'h3C with word_valid at edge 8.
REQ-032 word_ready held low 20 cycles after word_valid -> word, sel and word_valid stable throughout; ready pulse -> IDLE, busy=0 next cycle.
REQ-033 CONTINUOUS=1, D changes 8'h0F -> 8'hF0 during the first scan's DONE -> second word=8'hF0, valid 16 edges after the first handshake.
REQ-034 abort at sel=5 together with start -> IDLE, word unchanged (8'h00 after reset), no word_valid; a new start then yields a correct full scan.
REQ-035 rst asserted at sel=3, start held high during rst -> immediate IDLE, all outputs at reset values; scan begins on the first edge after release.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared types and sizes for the 8-channel mux scan sequencer.
package mux_scan_pkg;

  localparam int NUM_CH   = 8;
  localparam int SEL_W    = 3;
  localparam int SETTLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  // With no settle time a channel goes straight to sampling.
  function automatic state_t scan_entry(input int settle_cycles);
    return (settle_cycles == 0) ? ST_SAMPLE : ST_SETTLE;
  endfunction

endpackage

// File: rtl/mux_scan_sequencer.sv
// Steps an external 8:1 mux through all channels, samples each after a settle
// delay, and presents the assembled word with a valid/ready handshake.
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter bit CONTINUOUS    = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [SEL_W-1:0]  sel,
  input  logic              mux_y,
  output logic              busy,
  output logic [NUM_CH-1:0] word,
  output logic              word_valid,
  input  logic              word_ready
);

  localparam state_t ENTRY = scan_entry(SETTLE_CYCLES);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST =
    SETTLE_W'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  state_t              state;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [NUM_CH-1:0]   shadow;

  // sel doubles as the channel index, so the mux sees it directly from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      sel        <= '0;
      settle_cnt <= '0;
      shadow     <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      busy       <= 1'b0;
    end else if (abort) begin
      state      <= ST_IDLE;
      sel        <= '0;
      settle_cnt <= '0;
      shadow     <= '0;
      word_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ENTRY;
            sel        <= '0;
            settle_cnt <= '0;
            busy       <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            state      <= ST_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        ST_SAMPLE: begin
          shadow[sel] <= mux_y;
          if (sel == LAST_CH) begin
            word       <= {mux_y, shadow[NUM_CH-2:0]};
            word_valid <= 1'b1;
            state      <= ST_DONE;
          end else begin
            sel   <= sel + 1'b1;
            state <= ENTRY;
          end
        end
        ST_DONE: begin
          if (word_ready) begin
            word_valid <= 1'b0;
            sel        <= '0;
            settle_cnt <= '0;
            if (CONTINUOUS) begin
              state <= ENTRY;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
